// File: rtl/des_key_schedule_pkg.sv
// Shared constants for the DES key schedule: permutation tables, per-step
// rotation amounts, FSM state type and the 28-bit rotate helper.
package des_key_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Index 0 is the leftmost element; entry i is the shift applied at output step i.
    localparam logic [0:15][1:0] ENC_SHIFT = {
        2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
        2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
    };

    // Decrypt starts from the unrotated CD0 (= CD16), then walks the encrypt shifts backwards.
    localparam logic [0:15][1:0] DEC_SHIFT = {
        2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
        2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
    };

    // DES bit numbers (1 = MSB) selected for each PC-1 output bit, output bit 1 first.
    localparam int PC1_TAB [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };

    localparam int PC2_TAB [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    // dir = 0 rotates left, dir = 1 rotates right; amounts above 2 never occur.
    function automatic logic [27:0] rot28(input logic [27:0] value,
                                          input logic [1:0]  amt,
                                          input logic        dir);
        logic [27:0] r;
        case ({dir, amt})
            3'b0_01: r = {value[26:0], value[27]};
            3'b0_10: r = {value[25:0], value[27:26]};
            3'b1_01: r = {value[0], value[27:1]};
            3'b1_10: r = {value[1:0], value[27:2]};
            default: r = value;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/des_key_schedule_if.sv
// Key-load and round-key streaming handshakes of the DES key schedule.
interface des_key_schedule_if;
    logic        key_valid_i;
    logic        key_ready_o;
    logic [63:0] key_i;
    logic        decrypt_i;
    logic        rk_valid_o;
    logic        rk_ready_i;
    logic [47:0] rk_o;
    logic [3:0]  rk_idx_o;

    modport master (
        output key_valid_i, key_i, decrypt_i, rk_ready_i,
        input  key_ready_o, rk_valid_o, rk_o, rk_idx_o
    );

    modport slave (
        input  key_valid_i, key_i, decrypt_i, rk_ready_i,
        output key_ready_o, rk_valid_o, rk_o, rk_idx_o
    );
endinterface

// File: rtl/des_key_schedule_pc1.sv
// PC-1: drops the 8 parity bits of a 64-bit DES key and permutes the rest into C||D.
module p_box_64_56
    import des_key_pkg::*;
(
    input  logic [63:0] i_din,
    output logic [55:0] o_dout
);
    for (genvar g = 0; g < 56; g++) begin : g_bit
        assign o_dout[55-g] = i_din[64-PC1_TAB[g]];
    end
endmodule

// File: rtl/des_key_schedule_pc2.sv
// PC-2: compresses the 56-bit C||D register into a 48-bit round key.
module p_box_56_48
    import des_key_pkg::*;
(
    input  logic [55:0] i_din,
    output logic [47:0] o_dout
);
    for (genvar g = 0; g < 48; g++) begin : g_bit
        assign o_dout[47-g] = i_din[56-PC2_TAB[g]];
    end
endmodule

// File: rtl/des_key_schedule.sv
// Iterative DES key schedule: one rotating C/D register streams the 16 round keys
// in encrypt (K1..K16) or decrypt (K16..K1) order over a valid/ready handshake.
module des_key_schedule
    import des_key_pkg::*;
#(
    parameter int NUM_ROUNDS = 16
) (
    input  logic               clk,
    input  logic               rst,
    des_key_schedule_if.slave  bus,
    output logic               busy_o,
    output logic               done_o
);
    localparam logic [3:0] LAST_IDX = 4'(NUM_ROUNDS - 1);

    state_t      r_state, w_state_nxt;
    logic [55:0] r_cd;
    logic        r_mode;
    logic [3:0]  r_idx;
    logic        r_done;

    logic [55:0] w_pc1, w_next_cd;
    logic [47:0] w_pc2;
    logic [1:0]  w_amt;
    logic        w_key_ready, w_rk_valid, w_busy;
    logic        w_key_hs, w_rk_hs, w_last;

    p_box_64_56 u_pc1 (.i_din(bus.key_i),  .o_dout(w_pc1));
    p_box_56_48 u_pc2 (.i_din(w_next_cd), .o_dout(w_pc2));

    // The round key on the bus is always PC-2 of the rotated value, so the register
    // only advances on a handshake and the output holds under backpressure.
    assign w_amt     = r_mode ? DEC_SHIFT[r_idx] : ENC_SHIFT[r_idx];
    assign w_next_cd = {rot28(r_cd[55:28], w_amt, r_mode),
                        rot28(r_cd[27:0],  w_amt, r_mode)};

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_key_ready = 1'b0;
        w_rk_valid  = 1'b0;
        w_busy      = 1'b0;
        w_key_hs    = 1'b0;
        w_rk_hs     = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            IDLE: begin
                w_key_ready = !rst;
                w_key_hs    = bus.key_valid_i && !rst;
                if (w_key_hs) w_state_nxt = RUN;
            end
            RUN: begin
                w_rk_valid = 1'b1;
                w_busy     = 1'b1;
                w_rk_hs    = bus.rk_ready_i;
                w_last     = w_rk_hs && (r_idx == LAST_IDX);
                if (w_last) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cd   <= '0;
            r_mode <= 1'b0;
            r_idx  <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= w_last;
            if (w_key_hs) begin
                r_cd   <= w_pc1;
                r_mode <= bus.decrypt_i;
                r_idx  <= '0;
            end else if (w_rk_hs) begin
                r_cd  <= w_next_cd;
                r_idx <= w_last ? 4'd0 : r_idx + 4'd1;
            end
        end
    end

    assign bus.key_ready_o = w_key_ready;
    assign bus.rk_valid_o  = w_rk_valid;
    assign bus.rk_o        = w_rk_valid ? w_pc2 : '0;
    assign bus.rk_idx_o    = r_idx;
    assign busy_o          = w_busy;
    assign done_o          = r_done;

endmodule

// File: tb/tb_des_key_schedule.sv
// Bench for des_key_schedule: a cumulative-shift DES key schedule model checked every cycle.
module tb_des_key_schedule;

    localparam int PC1_T [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };
    localparam int PC2_T [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };
    localparam int SH [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
    localparam logic [63:0] KEY = 64'h133457799BBCDFF1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy, done;
    int   checks = 0;
    int   errors = 0;

    des_key_schedule_if bus ();

    des_key_schedule #(.NUM_ROUNDS(16)) dut (
        .clk    (clk),
        .rst    (rst),
        .bus    (bus.slave),
        .busy_o (busy),
        .done_o (done)
    );

    always #5 clk = ~clk;

    // Round key Kr (r = 1..16) straight from the DES definition: total shift then PC-2.
    function automatic logic [47:0] model_key(input logic [63:0] k, input int r);
        logic [55:0] cd;
        logic [27:0] c, d;
        logic [47:0] o;
        int tot;
        for (int i = 0; i < 56; i++) cd[55-i] = k[64-PC1_T[i]];
        c = cd[55:28];
        d = cd[27:0];
        tot = 0;
        for (int i = 0; i < r; i++) tot += SH[i];
        tot = tot % 28;
        c = (c << tot) | (c >> (28 - tot));
        d = (d << tot) | (d >> (28 - tot));
        cd = {c, d};
        for (int i = 0; i < 48; i++) o[47-i] = cd[56-PC2_T[i]];
        return o;
    endfunction

    function automatic logic [47:0] exp_rk(input logic [63:0] k, input logic dec, input int idx);
        return model_key(k, dec ? 16 - idx : idx + 1);
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Model state, owned by the compare process.
    logic        m_run = 1'b0;
    int          m_idx = 0;
    logic        m_dec = 1'b0;
    logic [63:0] m_key = '0;
    logic        m_done_exp = 1'b0;
    logic [47:0] cap [16];

    always @(negedge clk) begin
        if (rst) begin
            m_run      = 1'b0;
            m_idx      = 0;
            m_done_exp = 1'b0;
        end else begin
            chk("busy", busy, m_run);
            chk("rk_valid", bus.rk_valid_o, m_run);
            chk("key_ready", bus.key_ready_o, !m_run);
            chk("done", done, m_done_exp);
            if (m_run) begin
                chk("rk_idx", bus.rk_idx_o, m_idx);
                chk("rk_o", bus.rk_o, exp_rk(m_key, m_dec, m_idx));
            end
            m_done_exp = 1'b0;
            if (m_run && bus.rk_ready_i) begin
                cap[m_idx] = bus.rk_o;
                m_idx++;
                if (m_idx == 16) begin
                    m_run      = 1'b0;
                    m_idx      = 0;
                    m_done_exp = 1'b1;
                end
            end else if (!m_run && bus.key_valid_i) begin
                m_run = 1'b1;
                m_idx = 0;
                m_key = bus.key_i;
                m_dec = bus.decrypt_i;
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // mode 0: ready high, 1: random ready, 2: 5-cycle stall at idx 3 then random,
    // 3: stray key at idx 7, 4: reset at idx 9.
    task automatic run_sched(input logic [63:0] k, input logic d, input int mode, output int n);
        int  stall;
        bit  stalled, injected;
        stall    = 0;
        stalled  = 0;
        injected = 0;
        n        = 0;
        bus.rk_ready_i  = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
        bus.key_valid_i = 1'b1;
        bus.key_i       = k;
        bus.decrypt_i   = d;
        cyc(1);
        bus.key_valid_i = 1'b0;
        while (busy && n < 400) begin
            bus.key_valid_i = 1'b0;
            case (mode)
                1: bus.rk_ready_i = 1'($urandom_range(0, 1));
                2: begin
                    if (!stalled && bus.rk_idx_o == 4'd3) begin
                        bus.rk_ready_i = 1'b0;
                        stall++;
                        if (stall == 5) stalled = 1;
                    end else begin
                        bus.rk_ready_i = stalled ? 1'($urandom_range(0, 1)) : 1'b1;
                    end
                end
                3: begin
                    bus.rk_ready_i = 1'b1;
                    if (!injected && bus.rk_idx_o == 4'd7) begin
                        injected        = 1;
                        bus.key_valid_i = 1'b1;
                        bus.key_i       = 64'h0;
                        bus.decrypt_i   = 1'b1;
                        chk("key_ready_in_run", bus.key_ready_o, 1'b0);
                    end
                end
                4: begin
                    bus.rk_ready_i = 1'b1;
                    if (bus.rk_idx_o == 4'd9) begin
                        rst = 1'b1;
                        cyc(1);
                        rst = 1'b0;
                        #1;
                        chk("rst_mid_rk_valid", bus.rk_valid_o, 1'b0);
                        chk("rst_mid_busy", busy, 1'b0);
                        chk("rst_mid_key_ready", bus.key_ready_o, 1'b1);
                        chk("rst_mid_done", done, 1'b0);
                    end
                end
                default: bus.rk_ready_i = 1'b1;
            endcase
            cyc(1);
            n++;
        end
        bus.key_valid_i = 1'b0;
        if (n >= 400) begin
            checks++;
            errors++;
            $display("FAIL schedule_timeout: still busy after %0d cycles, required idle", n);
        end
    endtask

    logic [47:0] enc_ref [16];
    int          ncyc;

    initial begin
        bus.key_valid_i = 1'b0;
        bus.key_i       = '0;
        bus.decrypt_i   = 1'b0;
        bus.rk_ready_i  = 1'b0;
        cyc(3);
        rst = 1'b0;
        #1;
        chk("reset_rk_valid", bus.rk_valid_o, 1'b0);
        chk("reset_rk_o", bus.rk_o, 48'h0);
        chk("reset_rk_idx", bus.rk_idx_o, 4'd0);
        chk("reset_busy", busy, 1'b0);
        chk("reset_done", done, 1'b0);
        chk("reset_key_ready", bus.key_ready_o, 1'b1);

        // Pin the model against the published DES example.
        chk("model_K1", model_key(KEY, 1), 48'h1B02EFFC7072);
        chk("model_K2", model_key(KEY, 2), 48'h79AED9DBC9E5);
        chk("model_K16", model_key(KEY, 16), 48'hCB3D8B0E17F5);
        cyc(1);

        run_sched(KEY, 1'b0, 0, ncyc);
        chk("enc_cycles", ncyc, 16);
        for (int i = 0; i < 16; i++) enc_ref[i] = cap[i];
        chk("enc_idx0", enc_ref[0], 48'h1B02EFFC7072);
        chk("enc_idx1", enc_ref[1], 48'h79AED9DBC9E5);
        chk("enc_idx15", enc_ref[15], 48'hCB3D8B0E17F5);

        run_sched(KEY, 1'b1, 0, ncyc);
        chk("dec_idx0", cap[0], 48'hCB3D8B0E17F5);
        chk("dec_idx15", cap[15], 48'h1B02EFFC7072);
        for (int i = 0; i < 16; i++) chk("dec_reversed", cap[i], enc_ref[15-i]);

        run_sched(KEY, 1'b0, 2, ncyc);
        for (int i = 0; i < 16; i++) chk("backpressure_seq", cap[i], enc_ref[i]);

        run_sched(KEY, 1'b0, 3, ncyc);
        for (int i = 0; i < 16; i++) chk("stray_key_seq", cap[i], enc_ref[i]);

        run_sched(KEY, 1'b0, 4, ncyc);
        run_sched(KEY, 1'b0, 0, ncyc);
        chk("reload_idx0", cap[0], 48'h1B02EFFC7072);

        run_sched(KEY ^ 64'h0101010101010101, 1'b0, 0, ncyc);
        for (int i = 0; i < 16; i++) chk("parity_seq", cap[i], enc_ref[i]);

        for (int t = 0; t < 20; t++) begin
            run_sched({$urandom, $urandom}, 1'($urandom_range(0, 1)), 1, ncyc);
            cyc($urandom_range(0, 2));
        end
        cyc(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
